// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bus for nibble_serial_adder.
// master = operand producer / result consumer, slave = the adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built from one shared 4-bit carry-lookahead cell,
// processing one nibble per clock, least-significant nibble first.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s     = p ^ c[3:0];
    assign c_out = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] s_next;
    logic             cy;
    logic [IDXW-1:0]  idx;
    logic [3:0]       cell_s;
    logic             cell_cout;
    logic             last;
    logic             msb_cin;

    cla4 u_cla (
        .a     (a_r[3:0]),
        .b     (b_r[3:0]),
        .c_in  (cy),
        .s     (cell_s),
        .c_out (cell_cout)
    );

    // New nibble enters S_r from the top so the LS nibble ends up at bit 0.
    always_comb begin
        s_next = s_r >> 4;
        s_next[WIDTH-1 -: 4] = cell_s;
    end

    assign last    = (idx == IDXW'(NIB - 1));
    assign msb_cin = a_r[3] ^ b_r[3] ^ cell_s[3];

    assign bus.in_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            a_r           <= '0;
            b_r           <= '0;
            s_r           <= '0;
            cy            <= 1'b0;
            idx           <= '0;
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.c_out     <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        cy    <= bus.c_in;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_r <= a_r >> 4;
                    b_r <= b_r >> 4;
                    s_r <= s_next;
                    cy  <= cell_cout;
                    // idx stops on the last nibble; only a new accept clears it.
                    if (last) begin
                        bus.out_valid <= 1'b1;
                        bus.sum       <= s_next;
                        bus.c_out     <= cell_cout;
                        bus.ovf       <= msb_cin ^ cell_cout;
                        state         <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #20 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

    nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
    nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));

    logic [17:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec, input logic eo);
        int lat = 0;
        int guard = 0;
        while (!bus16.in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "_in_ready"}, 32'(bus16.in_ready), 1);
        bus16.a = av; bus16.b = bv; bus16.c_in = ci; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, 32'(lat), 4);
        check({tag, "_sum"}, 32'(bus16.sum), 32'(es));
        check({tag, "_c_out"}, 32'(bus16.c_out), 32'(ec));
        check({tag, "_ovf"}, 32'(bus16.ovf), 32'(eo));
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus16.out_valid), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0; bus16.out_ready = 1'b0;
        bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.c_in  = 1'b0; bus4.out_ready  = 1'b0;
        #5;
        check("rst_in_ready", 32'(bus16.in_ready), 0);
        check("rst_out_valid", 32'(bus16.out_valid), 0);
        check("rst_sum", 32'(bus16.sum), 0);
        check("rst_c_out", 32'(bus16.c_out), 0);
        check("rst_ovf", 32'(bus16.ovf), 0);
        @(posedge clk); #10;
        reset = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(bus16.in_ready), 1);
        @(posedge clk); #1;

        op16("all_ones_plus1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("pos_ovf",        16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16("neg_ovf",        16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        op16("cin_only",       16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        op16("carry_chain",    16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Backpressure, with junk operands offered during RUN and DONE.
        bus16.a = 16'hA5A5; bus16.b = 16'h1234; bus16.c_in = 1'b1; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.c_in = 1'b1;
        begin
            int lat = 0;
            while (!bus16.out_valid && lat < 20) begin
                check("bp_run_in_ready", 32'(bus16.in_ready), 0);
                @(posedge clk); #1; lat++;
            end
            check("bp_latency", 32'(lat), 4);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(bus16.out_valid), 1);
            check("bp_sum", 32'(bus16.sum), 32'h0000B7DA);
            check("bp_c_out", 32'(bus16.c_out), 0);
            check("bp_in_ready", 32'(bus16.in_ready), 0);
            @(posedge clk); #1;
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        check("bp_released", 32'(bus16.out_valid), 0);
        repeat (6) begin
            @(posedge clk); #1;
            check("bp_no_ghost", 32'(bus16.out_valid), 0);
        end

        // Asynchronous reset after two nibbles of a run.
        bus16.a = 16'h4321; bus16.b = 16'h0101; bus16.c_in = 1'b0; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #5;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus16.out_valid), 0);
        check("mid_rst_sum", 32'(bus16.sum), 0);
        check("mid_rst_in_ready", 32'(bus16.in_ready), 0);
        #10;
        reset = 1'b0;
        @(posedge clk); #1;
        op16("after_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Random back-to-back stream with random out_ready.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [15:0] av;
                    logic [15:0] bv;
                    logic        ci;
                    logic [16:0] full;
                    logic        ov;
                    int          guard;
                    av = 16'($urandom); bv = 16'($urandom); ci = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    bus16.a = av; bus16.b = bv; bus16.c_in = ci; bus16.in_valid = 1'b1;
                    guard = 0;
                    while (!bus16.in_ready && guard < 100) begin
                        @(posedge clk); #1; guard++;
                    end
                    if (guard >= 100) begin
                        check("rnd_accept_timeout", 32'(guard), 0);
                        bus16.in_valid = 1'b0;
                        break;
                    end
                    @(posedge clk); #1;
                    bus16.in_valid = 1'b0;
                    full = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
                    ov = (av[15] == bv[15]) && (full[15] != av[15]);
                    exp_q.push_back({ov, full});
                end
            end
            begin
                int got = 0;
                int cyc = 0;
                logic [17:0] e;
                while (got < 1000 && cyc < 30000) begin
                    @(posedge clk); #1; cyc++;
                    bus16.out_ready = 1'($urandom_range(0, 1));
                    if (bus16.out_valid && bus16.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rnd_unexpected", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rnd_sum", 32'(bus16.sum), 32'(e[15:0]));
                            check("rnd_c_out", 32'(bus16.c_out), 32'(e[16]));
                            check("rnd_ovf", 32'(bus16.ovf), 32'(e[17]));
                        end
                        got++;
                    end
                end
                if (got < 1000) check("rnd_timeout", 32'(got), 1000);
                bus16.out_ready = 1'b0;
            end
        join

        // WIDTH=4 instance: single-nibble latency and results.
        @(posedge clk); #1;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] av;
            logic [3:0] bv;
            logic       ci;
            logic [4:0] full;
            logic       ov;
            int         lat;
            av = 4'($urandom); bv = 4'($urandom); ci = 1'($urandom_range(0, 1));
            if (i == 0) begin av = 4'hF; bv = 4'h1; ci = 1'b0; end
            if (i == 1) begin av = 4'h7; bv = 4'h0; ci = 1'b1; end
            full = {1'b0, av} + {1'b0, bv} + {4'd0, ci};
            ov = (av[3] == bv[3]) && (full[3] != av[3]);
            check("w4_in_ready", 32'(bus4.in_ready), 1);
            bus4.a = av; bus4.b = bv; bus4.c_in = ci; bus4.in_valid = 1'b1;
            @(posedge clk); #1;
            bus4.in_valid = 1'b0;
            lat = 0;
            while (!bus4.out_valid && lat < 10) begin
                @(posedge clk); #1; lat++;
            end
            check("w4_latency", 32'(lat), 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                check("w4_hold", 32'(bus4.out_valid), 1);
            end
            check("w4_sum", 32'(bus4.sum), 32'(full[3:0]));
            check("w4_c_out", 32'(bus4.c_out), 32'(full[4]));
            check("w4_ovf", 32'(bus4.ovf), 32'(ov));
            bus4.out_ready = 1'b1;
            @(posedge clk); #1;
            bus4.out_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
